// File: rtl/fnd_watch_display.sv
// Four-digit common-anode FND driver for the watch: scans digits, converts
// hour/min/sec to BCD, blinks the colon and flashes the display in set mode.
module fnd_watch_display #(
   parameter int SCAN_DIV  = 100_000,
   parameter int BLINK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic [7:0] hour,
   input  logic [7:0] min,
   input  logic [7:0] sec,
   input  logic       disp_mode,
   input  logic       set_mode,
   output logic [3:0] com,
   output logic [7:0] seg_7
);

   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int BLINK_W = $clog2(BLINK_DIV);

   logic [SCAN_W-1:0]  scan_cnt;
   logic [BLINK_W-1:0] blink_cnt;
   logic               scan_tick;
   logic               blink_tick;
   logic               blink_phase;
   logic [1:0]         idx;
   logic [7:0]         snap_hi;
   logic [7:0]         snap_lo;

   logic [3:0] com_nxt;
   logic [7:0] seg_nxt;
   logic [7:0] field;
   logic       want_tens;
   logic [3:0] tens;
   logic [3:0] ones;
   logic [6:0] digit_seg;
   logic       dp_on;

   // Active-low a..g pattern for one decimal digit.
   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 7'h40;
         4'd1:    seg_code = 7'h79;
         4'd2:    seg_code = 7'h24;
         4'd3:    seg_code = 7'h30;
         4'd4:    seg_code = 7'h19;
         4'd5:    seg_code = 7'h12;
         4'd6:    seg_code = 7'h02;
         4'd7:    seg_code = 7'h78;
         4'd8:    seg_code = 7'h00;
         4'd9:    seg_code = 7'h10;
         default: seg_code = 7'h7F;
      endcase
   endfunction

   assign scan_tick  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
   assign blink_tick = (blink_cnt == BLINK_W'(BLINK_DIV - 1));

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         scan_cnt <= '0;
         idx      <= 2'd0;
      end else if (scan_tick) begin
         scan_cnt <= '0;
         idx      <= idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_tick) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   // Snapshot on the 3->0 wrap so a whole frame shows one consistent time.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         snap_hi <= 8'd0;
         snap_lo <= 8'd0;
      end else if (scan_tick && idx == 2'd3) begin
         snap_hi <= disp_mode ? min : hour;
         snap_lo <= disp_mode ? sec : min;
      end
   end

   always_comb begin
      com_nxt   = 4'b1110;
      field     = snap_lo;
      want_tens = 1'b0;
      case (idx)
         2'd0: begin
            com_nxt   = 4'b1110;
            field     = snap_lo;
            want_tens = 1'b0;
         end
         2'd1: begin
            com_nxt   = 4'b1101;
            field     = snap_lo;
            want_tens = 1'b1;
         end
         2'd2: begin
            com_nxt   = 4'b1011;
            field     = snap_hi;
            want_tens = 1'b0;
         end
         default: begin
            com_nxt   = 4'b0111;
            field     = snap_hi;
            want_tens = 1'b1;
         end
      endcase

      tens = 4'(field / 8'd10);
      ones = 4'(field % 8'd10);

      if (field >= 8'd100) digit_seg = 7'h3F;
      else                 digit_seg = seg_code(want_tens ? tens : ones);

      dp_on   = (idx == 2'd2) && (set_mode || blink_phase);
      seg_nxt = {~dp_on, digit_seg};
      // Set-mode flash blanks the digits but leaves the colon and scanning alone.
      if (set_mode && !blink_phase) seg_nxt[6:0] = 7'h7F;
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         com   <= 4'b1111;
         seg_7 <= 8'hFF;
      end else begin
         com   <= com_nxt;
         seg_7 <= seg_nxt;
      end
   end

endmodule
